ifetch_ctrl: RTL and testbench
==============================

# ifetch_ctrl

Instruction fetch controller that sequences reads from the 256-word, byte-addressed, combinational-read instruction memory and buffers the results for decode. It owns the fetch PC, drives the memory address every cycle, captures each returned word with its PC into a small prefetch queue, and presents the queue head to decode over a valid/ready handshake. Branch/jump redirects flush the queue and reload the fetch PC; start/stop inputs bring fetching up and down cleanly.

## Interface
- DEPTH, 4, prefetch queue entries; power of two, 2..8
- RESET_PC, 32'h0000_0000, fetch PC value at reset
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous reset, active-low
- start  input  1  pulse; begin fetching at start_pc (IDLE only)
- start_pc  input  32  byte address of first fetch
- stop  input  1  pulse; cease fetching, drain queue
- redirect  input  1  pulse; flush queue, reload fetch PC
- redirect_pc  input  32  new fetch byte address
- imem_addr  output  32  byte address to instruction memory (= fetch PC)
- imem_instr  input  32  combinational read data for imem_addr
- out_valid  output  1  queue head valid
- out_ready  input  1  decode accepts head
- out_instr  output  32  head instruction word
- out_pc  output  32  byte address of head instruction
- busy  output  1  state != IDLE
- count  output  $clog2(DEPTH)+1  queue occupancy

## Operation
- FSM states: IDLE (reset state), RUN, DRAIN.
  - IDLE: no pushes. start -> RUN, fetch_pc <= {start_pc[31:2],2'b00}.
  - RUN: push when allowed (below). stop -> DRAIN. start ignored.
  - DRAIN: no pushes; head continues to drain. count==0, or count==1 with a pop this cycle -> IDLE. start ignored.
- imem_addr = fetch_pc, combinational from register, every cycle in every state.
- pop = out_valid && out_ready.
- push = (state==RUN) && !stop && !redirect && (count<DEPTH || pop). On push: entry {fetch_pc, imem_instr} written at tail; fetch_pc <= fetch_pc + 4.
- Queue: circular buffer, head/tail pointers of $clog2(DEPTH) bits wrapping modulo DEPTH; count += push - pop.
- Full with simultaneous pop: push allowed, count unchanged.
- out_valid = (count != 0). out_instr/out_pc = head entry when valid, 32'h0 when empty.
- fetch_pc is 32-bit, wraps 32'hFFFF_FFFC -> 32'h0; memory decodes addr[9:2], so it wraps every 1 KB.
- Redirect (any state): count, head, tail <= 0; fetch_pc <= {redirect_pc[31:2],2'b00}; no push that cycle. A pop in the redirect cycle is a completed transfer (decode owns that word). State: RUN stays RUN (unless stop); DRAIN -> IDLE; IDLE stays IDLE.
- redirect+stop in RUN: redirect applied, state -> DRAIN, which exits to IDLE next cycle (queue empty).
- start_pc/redirect_pc bits [1:0] ignored.

## Timing
- Reset (rst_n low at clk edge): state IDLE, fetch_pc = RESET_PC, imem_addr = RESET_PC, count 0, out_valid 0, out_instr 0, out_pc 0, busy 0. Reset mid-operation discards all queue contents.
- start at edge N -> RUN, imem_addr = start_pc after N; first push at edge N+1; out_valid high after N+1 (2-cycle start-to-valid).
- Redirect at edge N -> out_valid 0 after N; first new instruction valid after N+1.
- Sustained throughput in RUN with out_ready=1: one instruction per cycle, count stays 1.
- out_ready=0: queue fills to DEPTH in DEPTH cycles, then fetch_pc holds.
- Outputs out_valid/out_instr/out_pc/count/busy depend only on registered state; no combinational path from out_ready, stop or redirect to any output.

## Test plan
- Reset then start, start_pc=0x40, out_ready=1, memory[n]=0xA000_0000+n: out_pc 0x40,0x44,0x48... with out_instr 0xA000_0010,0xA000_0011,... one per cycle, first valid 2 cycles after start.
- Backpressure: out_ready=0 for 10 cycles in RUN from 0x0: count saturates at 4, imem_addr holds 0x10; release -> out_pc 0x0,0x4,0x8,0xC,0x10 with no gaps or duplicates.
- Redirect to 0x203 with 3 queued entries and out_ready=1: head popped that cycle, next valid out_pc=0x200 one cycle later, stale entries never appear.
- stop with 3 entries queued: no further fetches, 3 entries drain, busy falls the cycle after last pop; start_pc=0x80 restart works.
- Wrap: start_pc=0xFFFF_FFF8: out_pc 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000; memory words 254, 255, 0.
- Reset asserted with full queue mid-RUN: next cycle out_valid 0, count 0, busy 0, imem_addr=RESET_PC; simultaneous stop+redirect returns to IDLE with empty queue.

Source files
------------

// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller: owns the fetch PC, prefetches words into a circular queue, hands the head to decode.
// Latency: first word is valid 2 cycles after start and 1 cycle after redirect; after that, one word per cycle.
// Backpressure: out_ready low fills the queue to DEPTH, then the fetch PC holds; redirect flushes the queue.
module ifetch_ctrl #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [31:0]              start_pc,
    input  logic                     stop,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    output logic [31:0]              imem_addr,
    input  logic [31:0]              imem_instr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_instr,
    output logic [31:0]              out_pc,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    state_t        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    entry_t        q_mem [DEPTH];

    logic pop;
    logic push;

    // Only word-aligned addresses are fetched; the low byte-offset bits are dropped.
    logic unused_low_bits;
    assign unused_low_bits = ^{start_pc[1:0], redirect_pc[1:0]};

    assign pop  = (count_q != '0) && out_ready;
    assign push = (state_q == RUN) && !stop && !redirect
                  && ((count_q < CW'(DEPTH)) || pop);

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q + CW'(push) - CW'(pop);

        if (push) begin
            tail_d     = tail_q + AW'(1);
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
        if (pop) begin
            head_d = head_q + AW'(1);
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = RUN;
                    fetch_pc_d = {start_pc[31:2], 2'b00};
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if ((count_q == '0) || ((count_q == CW'(1)) && pop)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A pop in the redirect cycle still completes; everything left behind is stale.
        if (redirect) begin
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            if (state_q == DRAIN) begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_mem[tail_q] <= '{pc: fetch_pc_q, instr: imem_instr};
        end
    end

    assign imem_addr = fetch_pc_q;
    assign out_valid = (count_q != '0);
    assign out_instr = out_valid ? q_mem[head_q].instr : 32'h0;
    assign out_pc    = out_valid ? q_mem[head_q].pc    : 32'h0;
    assign busy      = (state_q != IDLE);
    assign count     = count_q;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Bench for ifetch_ctrl: queue-based reference model checked every cycle, plus directed literal checks.
module tb_ifetch_ctrl;

    localparam int DEPTH = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] start_pc;
    logic        stop;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        busy;
    logic [2:0]  count;

    ifetch_ctrl #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_pc(start_pc),
        .stop(stop), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_addr(imem_addr), .imem_instr(imem_instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc),
        .busy(busy), .count(count)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [256];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 + i;
    end
    assign imem_instr = mem[imem_addr[9:2]];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Reference model: a plain queue of (pc, word) pairs and a fetch address.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        m_q[$];
    logic [31:0] m_pc      = RESET_PC;
    bit          m_running = 0;
    bit          m_draining = 0;
    bit          model_on  = 0;

    always @(posedge clk) begin
        bit can_pop, can_push;
        logic [31:0] word;
        if (!rst_n) begin
            m_q.delete();
            m_pc = RESET_PC;
            m_running = 0;
            m_draining = 0;
        end else begin
            word     = mem[m_pc[9:2]];
            can_pop  = (m_q.size() > 0) && out_ready;
            can_push = m_running && !stop && !redirect && ((m_q.size() < DEPTH) || can_pop);
            if (can_pop) void'(m_q.pop_front());
            if (can_push) begin
                m_q.push_back('{pc: m_pc, instr: word});
                m_pc = m_pc + 32'd4;
            end
            if (!m_running && !m_draining) begin
                if (start) begin
                    m_running = 1;
                    m_pc = {start_pc[31:2], 2'b00};
                end
            end else if (m_running) begin
                if (stop) begin
                    m_running = 0;
                    m_draining = 1;
                end
            end else if (m_q.size() == 0 || redirect) begin
                m_draining = 0;
            end
            if (redirect) begin
                m_q.delete();
                m_pc = {redirect_pc[31:2], 2'b00};
            end
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            chk("m_valid", {31'd0, out_valid}, {31'd0, m_q.size() != 0});
            chk("m_pc",    out_pc,    (m_q.size() != 0) ? m_q[0].pc    : 32'h0);
            chk("m_instr", out_instr, (m_q.size() != 0) ? m_q[0].instr : 32'h0);
            chk("m_count", {29'd0, count}, m_q.size());
            chk("m_busy",  {31'd0, busy}, {31'd0, m_running || m_draining});
            chk("m_addr",  imem_addr, m_pc);
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic pulse_start(input logic [31:0] pc);
        start = 1'b1;
        start_pc = pc;
        cyc();
        start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 0; start_pc = 0; stop = 0;
        redirect = 0; redirect_pc = 0; out_ready = 1'b1;
        cyc(2);
        model_on = 1;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_addr",  imem_addr, RESET_PC);
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        cyc();

        // Streaming from 0x40
        pulse_start(32'h0000_0040);
        chk("st_addr",   imem_addr, 32'h40);
        chk("st_notvld", {31'd0, out_valid}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("st_pc",    out_pc, 32'h40 + 4 * i);
            chk("st_instr", out_instr, 32'hA000_0010 + i);
            chk("st_count", {29'd0, count}, 32'd1);
        end

        // Backpressure from 0x0
        do_reset();
        out_ready = 1'b0;
        pulse_start(32'h0);
        cyc(10);
        chk("bp_count", {29'd0, count}, 32'd4);
        chk("bp_addr",  imem_addr, 32'h10);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_seq", out_pc, 32'h4 * i);
            cyc();
        end

        // Redirect with three queued
        do_reset();
        out_ready = 1'b0;
        pulse_start(32'h0);
        cyc(3);
        chk("rd_count", {29'd0, count}, 32'd3);
        redirect = 1'b1; redirect_pc = 32'h0000_0203; out_ready = 1'b1;
        cyc();
        redirect = 1'b0;
        chk("rd_flush", {31'd0, out_valid}, 32'd0);
        chk("rd_addr",  imem_addr, 32'h200);
        cyc();
        chk("rd_pc",    out_pc, 32'h200);
        chk("rd_instr", out_instr, 32'hA000_0080);
        cyc(3);

        // Stop and drain
        do_reset();
        out_ready = 1'b0;
        pulse_start(32'h0);
        cyc(3);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk("sp_busy",  {31'd0, busy}, 32'd1);
        chk("sp_count", {29'd0, count}, 32'd3);
        cyc(2);
        chk("sp_hold",  imem_addr, 32'hC);
        out_ready = 1'b1;
        cyc(2);
        chk("sp_busy2", {31'd0, busy}, 32'd1);
        cyc();
        chk("sp_idle",  {31'd0, busy}, 32'd0);
        chk("sp_empty", {29'd0, count}, 32'd0);
        pulse_start(32'h80);
        cyc();
        chk("sp_restart", out_pc, 32'h80);
        cyc(2);

        // PC wrap
        do_reset();
        pulse_start(32'hFFFF_FFF8);
        cyc();
        chk("wr_pc0", out_pc, 32'hFFFF_FFF8);
        chk("wr_in0", out_instr, 32'hA000_00FE);
        cyc();
        chk("wr_pc1", out_pc, 32'hFFFF_FFFC);
        chk("wr_in1", out_instr, 32'hA000_00FF);
        cyc();
        chk("wr_pc2", out_pc, 32'h0);
        chk("wr_in2", out_instr, 32'hA000_0000);

        // Reset with full queue, then stop+redirect together
        do_reset();
        out_ready = 1'b0;
        pulse_start(32'h100);
        cyc(6);
        chk("mr_full", {29'd0, count}, 32'd4);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        chk("mr_valid", {31'd0, out_valid}, 32'd0);
        chk("mr_count", {29'd0, count}, 32'd0);
        chk("mr_busy",  {31'd0, busy}, 32'd0);
        chk("mr_addr",  imem_addr, RESET_PC);
        pulse_start(32'h0);
        cyc(2);
        stop = 1'b1; redirect = 1'b1; redirect_pc = 32'h300;
        cyc();
        stop = 1'b0; redirect = 1'b0;
        chk("sr_drain", {31'd0, busy}, 32'd1);
        chk("sr_count", {29'd0, count}, 32'd0);
        cyc();
        chk("sr_idle",  {31'd0, busy}, 32'd0);
        chk("sr_addr",  imem_addr, 32'h300);

        // Redirect while draining goes straight to idle
        pulse_start(32'h0);
        cyc(3);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        redirect = 1'b1; redirect_pc = 32'h40;
        cyc();
        redirect = 1'b0;
        chk("dr_idle", {31'd0, busy}, 32'd0);
        cyc(2);

        model_on = 0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
